// File: rtl/tube_sched.sv
// tube_sched: round-robin issue scheduler and result router for a
// fixed-latency, non-stalling tube shared by NUM_REQ requesters.
// A tag pipe of LATENCY stages carries the requester id of each issued
// operation so the tube result can be steered back to its owner.
module tube_sched #(
   parameter int  REG_WIDTH       = 32,
   parameter int  NUM_REQ         = 4,
   parameter int  LATENCY         = 8,
   parameter int  MAX_OUTSTANDING = 2,
   parameter type T_tube_op       = logic
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*REG_WIDTH-1:0] req_data1,
   input  logic [NUM_REQ*REG_WIDTH-1:0] req_data2,
   input  T_tube_op [NUM_REQ-1:0]       req_op,
   output logic                         tube_in_valid,
   output logic [REG_WIDTH-1:0]         tube_in_data1,
   output logic [REG_WIDTH-1:0]         tube_in_data2,
   output T_tube_op                     tube_op,
   input  logic                         tube_out_valid,
   input  logic [REG_WIDTH-1:0]         tube_out_data,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic [REG_WIDTH-1:0]         resp_data,
   output logic                         error
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   // round-robin pointer
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;

   // per-requester in-flight counters
   logic [CW-1:0] cnt_q [NUM_REQ];
   logic [CW-1:0] cnt_d [NUM_REQ];
   logic [NUM_REQ-1:0] inc_v;
   logic [NUM_REQ-1:0] dec_v;

   // tag pipe: valid bits are control (reset), ids are payload (no reset)
   logic [LATENCY-1:0] tag_vld_q;
   logic [IDW-1:0]     tag_id_q [LATENCY];
   logic               tail_vld;
   logic [IDW-1:0]     tail_id;

   // arbitration results
   logic [NUM_REQ-1:0] elig;
   logic               gnt_vld;
   logic [IDW-1:0]     gnt_id;
   int                 idx;

   // response registers
   logic [NUM_REQ-1:0]   resp_valid_q;
   logic [NUM_REQ-1:0]   resp_valid_d;
   logic [REG_WIDTH-1:0] resp_data_q;
   logic [REG_WIDTH-1:0] resp_data_d;
   logic                 error_q;
   logic                 error_d;

   assign tail_vld = tag_vld_q[LATENCY-1];
   assign tail_id  = tag_id_q[LATENCY-1];

   // a requester may be granted only below its in-flight cap and outside reset
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING)) && !rst;
      end
   end

   // first eligible index at or after ptr wins; scanning downward lets the
   // closest index to ptr overwrite the farther candidates
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (elig[IDW'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
   end

   // one-hot grant and issue mux into the tube; all zero when idle
   always_comb begin
      req_ready     = '0;
      tube_in_valid = gnt_vld;
      tube_in_data1 = '0;
      tube_in_data2 = '0;
      tube_op       = '0;
      if (gnt_vld) begin
         req_ready[gnt_id] = 1'b1;
         tube_in_data1     = req_data1[gnt_id*REG_WIDTH +: REG_WIDTH];
         tube_in_data2     = req_data2[gnt_id*REG_WIDTH +: REG_WIDTH];
         tube_op           = req_op[gnt_id];
      end
   end

   // pointer moves to one past the granted index, holds when idle
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld) begin
         if (gnt_id == IDW'(NUM_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_id + 1'b1;
         end
      end
   end

   // pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // tag valid shift register aligned with the tube latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_q <= '0;
      end else begin
         tag_vld_q[0] <= gnt_vld;
         for (int s = 1; s < LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
         end
      end
   end

   // tag id shift register; meaningful only where the matching valid is set
   always_ff @(posedge clk) begin
      tag_id_q[0] <= gnt_id;
      for (int s = 1; s < LATENCY; s++) begin
         tag_id_q[s] <= tag_id_q[s-1];
      end
   end

   // counters: +1 on issue, -1 on a valid tail for that id, cancel when both;
   // eligibility keeps the increment below the cap, the zero test blocks underflow
   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         inc_v[i] = gnt_vld && (gnt_id == IDW'(i));
         dec_v[i] = tail_vld && (tail_id == IDW'(i)) && (cnt_q[i] != '0);
         cnt_d[i] = cnt_q[i];
         if (inc_v[i] && !dec_v[i]) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (dec_v[i] && !inc_v[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   // counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // route a result only when the tube and the tag pipe agree; any
   // disagreement latches the sticky error
   always_comb begin
      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      error_d      = error_q;
      if (tube_out_valid && tail_vld) begin
         resp_valid_d[tail_id] = 1'b1;
         resp_data_d           = tube_out_data;
      end
      if (tube_out_valid != tail_vld) begin
         error_d = 1'b1;
      end
   end

   // response and error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         error_q      <= 1'b0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         error_q      <= error_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign error      = error_q;

endmodule

// File: tb/tb_tube_sched.sv
// Directed bench for tube_sched with a behavioural 8-cycle tube model.
module tb_tube_sched;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int L  = 8;
   localparam int MO = 2;
   typedef logic [1:0] op_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_data1;
   logic [N*W-1:0]   req_data2;
   op_t [N-1:0]      req_op;
   logic             tube_in_valid;
   logic [W-1:0]     tube_in_data1;
   logic [W-1:0]     tube_in_data2;
   op_t              tube_op;
   logic             tube_out_valid;
   logic [W-1:0]     tube_out_data;
   logic [N-1:0]     resp_valid;
   logic [W-1:0]     resp_data;
   logic             error;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   tube_sched #(
      .REG_WIDTH(W), .NUM_REQ(N), .LATENCY(L), .MAX_OUTSTANDING(MO), .T_tube_op(op_t)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data1(req_data1), .req_data2(req_data2), .req_op(req_op),
      .tube_in_valid(tube_in_valid), .tube_in_data1(tube_in_data1),
      .tube_in_data2(tube_in_data2), .tube_op(tube_op),
      .tube_out_valid(tube_out_valid), .tube_out_data(tube_out_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .error(error)
   );

   always #5 clk = ~clk;

   // tube model: 0 add, 1 sub, 2 xor, 3 and
   function automatic logic [W-1:0] alu(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd2: return a ^ b;
         default: return a & b;
      endcase
   endfunction

   logic [L-1:0] tv;
   logic [W-1:0] td [L];
   logic         inj;

   always @(posedge clk or posedge rst) begin
      if (rst) tv <= '0;
      else     tv <= {tv[L-2:0], tube_in_valid};
   end

   always @(posedge clk) begin
      td[0] <= alu(tube_op, tube_in_data1, tube_in_data2);
      for (int i = 1; i < L; i++) td[i] <= td[i-1];
   end

   assign tube_out_valid = tv[L-1] | inj;
   assign tube_out_data  = td[L-1];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int          gseq [8];
   logic [W-1:0] rexp [N];

   initial begin
      gseq = '{1, 2, 3, 0, 1, 2, 3, 0};
      rexp = '{32'h13, 32'h0E, 32'h11, 32'h03};
      rst = 1'b1;
      inj = 1'b0;
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
         req_data1[i*W +: W] = 32'h10 + i;
         req_data2[i*W +: W] = 32'h3;
         req_op[i] = op_t'(i);
      end
      req_data1[0 +: W] = 32'd5;

      // reset state, with requests pending during reset
      repeat (2) cyc();
      req_valid = 4'hF;
      #1;
      check("rst_ready", W'(req_ready), 0);
      check("rst_tube_in_valid", W'(tube_in_valid), 0);
      check("rst_resp_valid", W'(resp_valid), 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_error", W'(error), 0);
      cyc();

      // single issue from requester 0: 5 + 3
      rst = 1'b0;
      req_valid = 4'b0001;
      #1;
      check("t1_ready", W'(req_ready), 32'b0001);
      check("t1_tube_in_valid", W'(tube_in_valid), 1);
      check("t1_data1", tube_in_data1, 5);
      check("t1_data2", tube_in_data2, 3);
      check("t1_op", W'(tube_op), 0);
      for (int c = 1; c <= 8; c++) begin
         cyc();
         req_valid = '0;
         #1;
         check("t1_no_resp", W'(resp_valid), 0);
      end
      cyc(); #1;
      check("t1_resp_valid", W'(resp_valid), 32'b0001);
      check("t1_resp_data", resp_data, 8);
      cyc(); #1;
      check("t1_resp_clear", W'(resp_valid), 0);
      check("t1_resp_hold", resp_data, 8);

      // all requesters valid, pointer starts at 1
      req_data1[0 +: W] = 32'h10;
      for (int k = 0; k < 8; k++) begin
         cyc();
         req_valid = 4'hF;
         #1;
         check("t2_ready", W'(req_ready), 32'd1 << gseq[k]);
         check("t2_data1", tube_in_data1, 32'h10 + gseq[k]);
      end
      cyc();
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         cyc(); #1;
         check("t2_resp_valid", W'(resp_valid), 32'd1 << gseq[k]);
         check("t2_resp_data", resp_data, rexp[gseq[k]]);
      end
      repeat (4) cyc();

      // requester 2 alone hits its cap of two
      for (int c = 0; c <= 9; c++) begin
         cyc();
         req_valid = 4'b0100;
         #1;
         check("t3_ready", W'(req_ready), (c <= 1 || c == 9) ? 32'b0100 : 32'b0);
         if (c == 9) begin
            check("t3_resp_valid", W'(resp_valid), 32'b0100);
            check("t3_resp_data", resp_data, 32'h11);
         end
      end
      cyc();
      req_valid = '0;
      #1;
      check("t3_resp_valid2", W'(resp_valid), 32'b0100);
      repeat (10) cyc();

      // grant to 1 moves ptr to 2, then 1 and 3 compete
      req_valid = 4'b0010;
      #1;
      check("t4_setup", W'(req_ready), 32'b0010);
      cyc(); req_valid = 4'b1010; #1;
      check("t4_g0", W'(req_ready), 32'b1000);
      cyc(); #1;
      check("t4_g1", W'(req_ready), 32'b0010);
      cyc(); #1;
      check("t4_g2", W'(req_ready), 32'b1000);
      cyc();
      req_valid = '0;
      repeat (14) cyc();

      // spurious tube result with no tag
      check("t5_error_before", W'(error), 0);
      inj = 1'b1;
      cyc();
      inj = 1'b0;
      #1;
      check("t5_error_set", W'(error), 1);
      check("t5_no_resp", W'(resp_valid), 0);
      repeat (3) cyc();
      check("t5_error_sticky", W'(error), 1);
      rst = 1'b1;
      #1;
      check("t5_error_cleared", W'(error), 0);
      cyc();

      // three ops in flight, then a one-cycle reset
      rst = 1'b0;
      req_valid = 4'b0111;
      #1;
      check("t6_g0", W'(req_ready), 32'b0001);
      cyc(); #1;
      check("t6_g1", W'(req_ready), 32'b0010);
      cyc(); #1;
      check("t6_g2", W'(req_ready), 32'b0100);
      cyc();
      req_valid = '0;
      cyc();
      rst = 1'b1;
      req_valid = 4'hF;
      #1;
      check("t6_rst_ready", W'(req_ready), 0);
      check("t6_rst_resp", W'(resp_valid), 0);
      cyc();
      rst = 1'b0;
      req_valid = 4'b1000;
      #1;
      check("t6_first_after_rst", W'(req_ready), 32'b1000);
      cyc(); req_valid = 4'b0001; #1;
      check("t6_r0_a", W'(req_ready), 32'b0001);
      cyc(); #1;
      check("t6_r0_b", W'(req_ready), 32'b0001);
      cyc();
      req_valid = '0;
      #1;
      check("t6_flushed", W'(resp_valid), 0);
      for (int c = 9; c <= 13; c++) begin
         cyc(); #1;
         check("t6_flushed", W'(resp_valid), 0);
      end
      cyc(); #1;
      check("t6_resp3", W'(resp_valid), 32'b1000);
      check("t6_resp3_data", resp_data, 32'h03);
      cyc(); #1;
      check("t6_resp0_a", W'(resp_valid), 32'b0001);
      check("t6_resp0_a_data", resp_data, 32'h13);
      cyc(); #1;
      check("t6_resp0_b", W'(resp_valid), 32'b0001);
      check("t6_error", W'(error), 0);
      cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
